// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants for the 6502 interrupt sequencer: vectors, stack page,
// sequencer state encodings, status-bit positions and event kinds.
package interrupt_sequencer_pkg;

  localparam logic [15:0] NMI_VEC_DEF    = 16'hFFFA;
  localparam logic [15:0] RST_VEC_DEF    = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC_DEF    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;

  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_I = 2;

  typedef enum logic [1:0] {
    EV_RST = 2'd0,
    EV_NMI = 2'd1,
    EV_BRK = 2'd2,
    EV_IRQ = 2'd3
  } event_kind_e;

  localparam logic [3:0] S_RST_PEND = 4'd0;
  localparam logic [3:0] S_IDLE     = 4'd1;
  localparam logic [3:0] S_DUMMY1   = 4'd2;
  localparam logic [3:0] S_DUMMY2   = 4'd3;
  localparam logic [3:0] S_PUSH_PCH = 4'd4;
  localparam logic [3:0] S_PUSH_PCL = 4'd5;
  localparam logic [3:0] S_PUSH_P   = 4'd6;
  localparam logic [3:0] S_VEC_LO   = 4'd7;
  localparam logic [3:0] S_VEC_HI   = 4'd8;
  localparam logic [3:0] S_LOAD     = 4'd9;

  // Pushed status always has U set; B distinguishes BRK from hardware interrupts.
  function automatic logic [7:0] push_status(input logic [7:0] p, input logic b);
    logic [7:0] r;
    r      = p;
    r[P_U] = 1'b1;
    r[P_B] = b;
    return r;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI input synchronizer and falling-edge pending latch, cleared by the
// sequencer's acknowledge when the NMI vector is committed.
module interrupt_sequencer_nmi_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic nmi_n_i,
  input  logic ack_i,
  output logic pend_o
);

  logic s1_q, s2_q, pend_q;
  logic fall;

  // Edge is taken between the two sync stages; pend_q acts as the second
  // resolving flop, and pend_o exposes the edge one cycle early for hijack.
  assign fall   = s2_q & ~s1_q;
  assign pend_o = pend_q | fall;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      s1_q   <= nmi_n_i;
      s2_q   <= s1_q;
      pend_q <= fall | (pend_q & ~ack_i);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: arbitrates at instruction boundaries,
// pushes PCH/PCL/P, fetches the vector and hands the new PC to the core.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [15:0] NMI_VEC    = NMI_VEC_DEF,
  parameter logic [15:0] RST_VEC    = RST_VEC_DEF,
  parameter logic [15:0] IRQ_VEC    = IRQ_VEC_DEF,
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        rdy_i,
  input  logic        irq_n_i,
  input  logic        nmi_n_i,
  input  logic        i_flag_i,
  input  logic        sync_i,
  input  logic        brk_i,
  input  logic [15:0] pc_in_i,
  input  logic [7:0]  p_in_i,
  input  logic [7:0]  sp_in_i,
  input  logic [7:0]  data_in_i,
  output logic        busy_o,
  output logic [15:0] addr_o,
  output logic [7:0]  data_out_o,
  output logic        we_o,
  output logic        sp_dec_o,
  output logic        vec_pull_o,
  output logic        pc_load_o,
  output logic [15:0] pc_out_o,
  output logic        set_i_o,
  output logic        nmi_ack_o
);

  logic [3:0]  state_q, state_d;
  event_kind_e kind_q, kind_d;
  logic [7:0]  sp_q, vec_lo_q, vec_hi_q;
  logic        vec_nmi_q;
  logic        nmi_pend;
  logic [15:0] vec_base;
  logic        push_we;

  interrupt_sequencer_nmi_edge_detect u_nmi (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .nmi_n_i (nmi_n_i),
    .ack_i   (nmi_ack_o),
    .pend_o  (nmi_pend)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    if (rdy_i) begin
      case (state_q)
        S_RST_PEND: begin
          kind_d  = EV_RST;
          state_d = S_DUMMY1;
        end
        S_IDLE: begin
          if (sync_i) begin
            if (nmi_pend) begin
              kind_d  = EV_NMI;
              state_d = S_DUMMY1;
            end else if (brk_i) begin
              kind_d  = EV_BRK;
              state_d = S_DUMMY1;
            end else if (!irq_n_i && !i_flag_i) begin
              kind_d  = EV_IRQ;
              state_d = S_DUMMY1;
            end
          end
        end
        S_DUMMY1, S_DUMMY2, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI:
          state_d = state_q + 4'd1;
        S_LOAD:  state_d = S_IDLE;
        default: state_d = S_RST_PEND;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_RST_PEND;
      kind_q    <= EV_RST;
      sp_q      <= 8'h00;
      vec_lo_q  <= 8'h00;
      vec_hi_q  <= 8'h00;
      vec_nmi_q <= 1'b0;
    end else if (rdy_i) begin
      state_q <= state_d;
      kind_q  <= kind_d;
      if (state_q == S_DUMMY1) sp_q <= sp_in_i;
      // A late NMI steals an IRQ/BRK entry; reset entries are never stolen.
      if (state_q == S_PUSH_P)
        vec_nmi_q <= (kind_q == EV_NMI) || ((kind_q != EV_RST) && nmi_pend);
      if (state_q == S_VEC_HI) vec_lo_q <= data_in_i;
      if (state_q == S_LOAD)   vec_hi_q <= data_in_i;
    end
  end

  assign vec_base = (kind_q == EV_RST) ? RST_VEC : (vec_nmi_q ? NMI_VEC : IRQ_VEC);
  assign push_we  = rdy_i && (kind_q != EV_RST);
  assign busy_o   = (state_q >= S_DUMMY1) && (state_q <= S_LOAD);
  assign pc_out_o = (state_q == S_LOAD) ? {data_in_i, vec_lo_q} : {vec_hi_q, vec_lo_q};

  always_comb begin
    addr_o     = 16'h0000;
    data_out_o = 8'h00;
    we_o       = 1'b0;
    sp_dec_o   = 1'b0;
    vec_pull_o = 1'b0;
    pc_load_o  = 1'b0;
    set_i_o    = 1'b0;
    nmi_ack_o  = 1'b0;
    case (state_q)
      S_DUMMY1, S_DUMMY2: addr_o = pc_in_i;
      S_PUSH_PCH: begin
        addr_o     = {STACK_PAGE, sp_q};
        data_out_o = pc_in_i[15:8];
        we_o       = push_we;
        sp_dec_o   = rdy_i;
      end
      S_PUSH_PCL: begin
        addr_o     = {STACK_PAGE, sp_q - 8'd1};
        data_out_o = pc_in_i[7:0];
        we_o       = push_we;
        sp_dec_o   = rdy_i;
      end
      S_PUSH_P: begin
        addr_o     = {STACK_PAGE, sp_q - 8'd2};
        data_out_o = push_status(p_in_i, kind_q == EV_BRK);
        we_o       = push_we;
        sp_dec_o   = rdy_i;
      end
      S_VEC_LO: begin
        addr_o     = vec_base;
        vec_pull_o = 1'b1;
        nmi_ack_o  = rdy_i && vec_nmi_q;
      end
      S_VEC_HI: begin
        addr_o     = vec_base + 16'd1;
        vec_pull_o = 1'b1;
      end
      S_LOAD: begin
        // Keep the high vector address on the bus so a stalled load still sees it.
        addr_o    = vec_base + 16'd1;
        pc_load_o = rdy_i;
        set_i_o   = rdy_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer with a synchronous ROM
// model for the vectors and a bus monitor logging writes and strobes.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, rdy, irq_n, nmi_n, i_flag, sync, brk;
  logic [15:0] pc_in;
  logic [7:0]  p_in, sp_in, data_in;
  logic        busy, we, sp_dec, vec_pull, pc_load, set_i, nmi_ack;
  logic [15:0] addr, pc_out;
  logic [7:0]  data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0;

  logic [23:0] wr_q[$];
  logic [15:0] vaddr_q[$];
  int          n_spdec, n_ack, n_load, n_busy, load_cyc;
  logic [15:0] load_pc;
  logic        load_seti;

  interrupt_sequencer dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .rdy_i      (rdy),
    .irq_n_i    (irq_n),
    .nmi_n_i    (nmi_n),
    .i_flag_i   (i_flag),
    .sync_i     (sync),
    .brk_i      (brk),
    .pc_in_i    (pc_in),
    .p_in_i     (p_in),
    .sp_in_i    (sp_in),
    .data_in_i  (data_in),
    .busy_o     (busy),
    .addr_o     (addr),
    .data_out_o (data_out),
    .we_o       (we),
    .sp_dec_o   (sp_dec),
    .vec_pull_o (vec_pull),
    .pc_load_o  (pc_load),
    .pc_out_o   (pc_out),
    .set_i_o    (set_i),
    .nmi_ack_o  (nmi_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd_mem(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h21;
      16'hFFFB: return 8'h90;
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'hC0;
      16'hFFFE: return 8'h34;
      16'hFFFF: return 8'h80;
      default:  return 8'hEA;
    endcase
  endfunction

  always @(posedge clk) data_in <= rd_mem(addr);

  always @(negedge clk) begin
    if (we) wr_q.push_back({addr, data_out});
    if (vec_pull) vaddr_q.push_back(addr);
    if (sp_dec) n_spdec++;
    if (nmi_ack) n_ack++;
    if (busy) n_busy++;
    if (pc_load) begin
      n_load++;
      load_cyc  = cyc;
      load_pc   = pc_out;
      load_seti = set_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wr_q.delete();
    vaddr_q.delete();
    n_spdec = 0;
    n_ack   = 0;
    n_load  = 0;
    n_busy  = 0;
    load_cyc = 0;
    load_pc  = 16'h0;
    load_seti = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] wr_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 24'hxxxxxx;
  endfunction

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (n_load == 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_pc_load_seen"}, {31'd0, n_load != 0}, 32'd1);
  endtask

  task automatic start_event(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                             input logic irq_lvl_n, input logic iflag, input logic brk_v);
    pc_in  = pc;
    p_in   = p;
    sp_in  = sp;
    irq_n  = irq_lvl_n;
    i_flag = iflag;
    brk    = brk_v;
    sync   = 1'b1;
    t0     = cyc;
    tick();
    sync   = 1'b0;
    brk    = 1'b0;
    irq_n  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b1;
    sync = 1'b0; brk = 1'b0; pc_in = 16'h0; p_in = 8'h0; sp_in = 8'h0;
    clear();

    // Reset state
    tick(); tick();
    @(negedge clk); #1;
    chk("rst_strobes", {25'd0, busy, we, sp_dec, vec_pull, pc_load, set_i, nmi_ack}, 32'd0);
    chk("rst_addr", {16'd0, addr}, 32'h0);
    chk("rst_pc_out", {16'd0, pc_out}, 32'h0);

    // Reset sequence after release
    tick();
    clear();
    rst_n = 1'b1;
    t0 = cyc;
    wait_load("rst");
    chk("rst_writes", wr_q.size(), 32'd0);
    chk("rst_sp_dec", n_spdec, 32'd3);
    chk("rst_vector", {16'd0, load_pc}, 32'hC000);
    chk("rst_set_i", {31'd0, load_seti}, 32'd1);
    chk("rst_latency", load_cyc - t0, 32'd8);
    tick(); tick();

    // IRQ entry
    clear();
    start_event(16'h1234, 8'h81, 8'hFD, 1'b0, 1'b0, 1'b0);
    wait_load("irq");
    chk("irq_nwr", wr_q.size(), 32'd3);
    chk("irq_wr0", {8'd0, wr_at(0)}, 32'h01FD12);
    chk("irq_wr1", {8'd0, wr_at(1)}, 32'h01FC34);
    chk("irq_wr2", {8'd0, wr_at(2)}, 32'h01FBA1);
    chk("irq_vector", {16'd0, load_pc}, 32'h8034);
    chk("irq_latency", load_cyc - t0, 32'd8);
    chk("irq_sp_dec", n_spdec, 32'd3);
    chk("irq_no_ack", n_ack, 32'd0);
    tick(); tick();

    // Masked IRQ, then BRK without sync
    clear();
    start_event(16'h2222, 8'h04, 8'hF0, 1'b0, 1'b1, 1'b0);
    irq_n = 1'b0;
    repeat (4) tick();
    irq_n = 1'b1;
    brk = 1'b1;
    i_flag = 1'b0;
    repeat (6) tick();
    brk = 1'b0;
    chk("masked_busy", n_busy, 32'd0);
    chk("masked_writes", wr_q.size(), 32'd0);

    // BRK with NMI edge arriving in PUSH_PCL: vector hijacked, B stays set
    clear();
    start_event(16'h4321, 8'h04, 8'hF0, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    nmi_n = 1'b0;
    wait_load("brk_nmi");
    chk("brk_wr0", {8'd0, wr_at(0)}, 32'h01F043);
    chk("brk_wr1", {8'd0, wr_at(1)}, 32'h01EF21);
    chk("brk_wr2", {8'd0, wr_at(2)}, 32'h01EE34);
    chk("brk_vec_addr", {16'd0, (vaddr_q.size() > 0) ? vaddr_q[0] : 16'h0}, 32'hFFFA);
    chk("brk_vector", {16'd0, load_pc}, 32'h9021);
    chk("brk_nmi_ack", n_ack, 32'd1);
    tick(); tick();
    nmi_n = 1'b1;
    tick(); tick(); tick();

    // NMI already pending beats BRK and IRQ at sync
    nmi_n = 1'b0;
    repeat (4) tick();
    clear();
    start_event(16'h1111, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_load("nmi");
    chk("nmi_wr2", {8'd0, wr_at(2)}, 32'h01FDEF);
    chk("nmi_vector", {16'd0, load_pc}, 32'h9021);
    chk("nmi_ack_once", n_ack, 32'd1);
    nmi_n = 1'b1;
    repeat (4) tick();

    // rdy low for three cycles in PUSH_PCL
    clear();
    start_event(16'h5678, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rdy = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    wait_load("rdy");
    chk("rdy_nwr", wr_q.size(), 32'd3);
    chk("rdy_wr1", {8'd0, wr_at(1)}, 32'h017F78);
    chk("rdy_wr2", {8'd0, wr_at(2)}, 32'h017E20);
    chk("rdy_latency", load_cyc - t0, 32'd11);
    chk("rdy_sp_dec", n_spdec, 32'd3);
    tick(); tick();

    // Stack wrap, then reset pulse in VEC_LO
    clear();
    start_event(16'hABCD, 8'hC3, 8'h01, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("wrap_wr0", {8'd0, wr_at(0)}, 32'h0101AB);
    chk("wrap_wr1", {8'd0, wr_at(1)}, 32'h0100CD);
    chk("wrap_wr2", {8'd0, wr_at(2)}, 32'h01FFE3);
    chk("wrap_in_vec_lo", {15'd0, vec_pull, addr}, 32'h1FFFE);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    clear();
    rst_n = 1'b1;
    t0 = cyc;
    wait_load("rerst");
    chk("rerst_writes", wr_q.size(), 32'd0);
    chk("rerst_sp_dec", n_spdec, 32'd3);
    chk("rerst_vector", {16'd0, load_pc}, 32'hC000);
    chk("rerst_latency", load_cyc - t0, 32'd8);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
